mod_if_burst_producer: RTL
==========================

MOD_IF_BURST_PRODUCER -- requirements
Module: mod_if_burst_producer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address width in bits.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width in bits.
REQ-003 Parameter BURST_LEN, default 4, range 1..255, SHALL set the number of beats per burst.
REQ-004 Parameter BASE_ADDR, default 8'h12 zero-extended to ADDR_W, SHALL set the first-beat address.
REQ-005 Parameter BASE_DATA, default 8'h34 zero-extended to DATA_W, SHALL set the first-beat data.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the asynchronous, active-low reset; low forces the reset state immediately.
REQ-008 start  input  1  SHALL be a one-cycle burst request, honoured only in IDLE.
REQ-009 abort  input  1  SHALL terminate an active burst, honoured only in REQ.
REQ-010 grant  input  1  SHALL be the consumer acceptance of the current beat.
REQ-011 req  output  1  SHALL be high while a beat is offered.
REQ-012 addr  output  ADDR_W  SHALL carry the address of the offered beat.
REQ-013 data  output  DATA_W  SHALL carry the data of the offered beat.
REQ-014 beat_cnt  output  8  SHALL count beats accepted in the current burst.
REQ-015 busy  output  1  SHALL be high in REQ and DONE.
REQ-016 done  output  1  SHALL pulse high for one cycle after the last beat is accepted.
REQ-017 req_inv  output  1  SHALL equal the logical inverse of req, combinationally.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-019 IDLE with start=1 SHALL move to REQ next cycle with addr=BASE_ADDR, data=BASE_DATA, beat_cnt=0, req=1.
REQ-020 In REQ, addr, data and req SHALL stay stable until a rising edge samples grant=1 (beat accepted).
REQ-021 On acceptance with beat_cnt<BURST_LEN-1: beat_cnt+1, addr+1, data+1, stay in REQ with req=1 (back-to-back beats, zero bubble).
REQ-022 addr and data increments SHALL wrap modulo 2^ADDR_W and 2^DATA_W respectively.
REQ-023 On acceptance with beat_cnt=BURST_LEN-1: beat_cnt+1, req=0, move to DONE; addr/data hold last-beat values.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE; beat_cnt holds until the next start.
REQ-025 abort=1 in REQ SHALL return to IDLE next cycle with req=0 and no done pulse; abort SHALL take priority over a same-cycle grant (beat not counted).
REQ-026 start outside IDLE and abort outside REQ SHALL be ignored.
REQ-027 grant while req=0 SHALL have no effect.
REQ-028 Latency start-to-req SHALL be 1 cycle; last-grant-to-done SHALL be 1 cycle.

Reset
REQ-029 While rst=0: state=IDLE, req=0, addr=0, data=0, beat_cnt=0, busy=0, done=0, req_inv=1.
REQ-030 rst asserted mid-burst SHALL abandon the burst with no done pulse; first start after release SHALL begin a fresh burst from BASE_ADDR/BASE_DATA.

Verification
REQ-031 Defaults, start, grant held high -> beats 12/34,13/35,14/36,15/37 on consecutive cycles, done one cycle after 4th grant, busy low after.
REQ-032 Defaults, start, grant low 3 cycles then high 1 cycle per beat -> addr/data stable during stalls, beat_cnt steps 0..4, single done.
REQ-033 BASE_ADDR=8'hFE, BASE_DATA=8'hFF, BURST_LEN=3, grant high -> addr FE,FF,00; data FF,00,01.
REQ-034 Abort and grant together on beat 2 -> req low next cycle, beat_cnt=1, no done; new start restarts at 12/34.
REQ-035 rst low during beat 3, then release and start -> all outputs at reset values during reset, new burst from 12/34, req_inv always equal to !req.
REQ-036 start pulsed during REQ and DONE, grant pulsed in IDLE -> no state, count or output change.

Source files
------------

// File: rtl/mod_if_burst_producer.sv
// Fixed-length burst producer: offers BURST_LEN beats with incrementing addr/data under a req/grant handshake.
// Three-state FSM (IDLE/REQ/DONE) with registered outputs and abort/reset cancellation.
module mod_if_burst_producer #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                BURST_LEN = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(8'h12),
    parameter logic [DATA_W-1:0] BASE_DATA = DATA_W'(8'h34)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic [7:0]        beat_cnt,
    output logic              busy,
    output logic              done,
    output logic              req_inv
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_nxt_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_nxt_s;
    logic              req_r;
    logic              req_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              last_s;

    assign last_s = (cnt_r == LAST_CNT);

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            data_r  <= '0;
            cnt_r   <= 8'd0;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            data_r  <= data_nxt_s;
            cnt_r   <= cnt_nxt_s;
            req_r   <= req_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic; abort outranks a same-cycle grant.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_REQ;
                else       state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (abort)                state_nxt_s = ST_IDLE;
                else if (grant && last_s) state_nxt_s = ST_DONE;
                else                      state_nxt_s = ST_REQ;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath logic: next values of the registered outputs.
    always_comb begin
        addr_nxt_s = addr_r;
        data_nxt_s = data_r;
        cnt_nxt_s  = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt_s = BASE_ADDR;
                    data_nxt_s = BASE_DATA;
                    cnt_nxt_s  = 8'd0;
                end else begin
                    cnt_nxt_s  = cnt_r;
                end
            end
            ST_REQ: begin
                if (!abort && grant) begin
                    cnt_nxt_s = cnt_r + 8'd1;
                    // The last beat keeps its addr/data visible through DONE.
                    if (!last_s) begin
                        addr_nxt_s = addr_r + ADDR_W'(1);
                        data_nxt_s = data_r + DATA_W'(1);
                    end else begin
                        addr_nxt_s = addr_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: cnt_nxt_s = cnt_r;
        endcase
        req_nxt_s  = (state_nxt_s == ST_REQ);
        busy_nxt_s = (state_nxt_s == ST_REQ) || (state_nxt_s == ST_DONE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    assign req      = req_r;
    assign addr     = addr_r;
    assign data     = data_r;
    assign beat_cnt = cnt_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign req_inv  = ~req_r;

endmodule
